alu_sequencer: RTL and testbench

Multi-cycle control unit that drives the ALU's opcode and operand inputs and consumes its result and flags. It accepts 32-bit instruction words over a valid/ready handshake and decodes each into the 7-bit ALU opcode. Operands come from an internal 8×32 register file. The unit captures the ALU result and flags, then writes the result back. It sits between the instruction source and the combinational ALU.

---
 rtl/alu_sequencer_if.sv | 30 +++
 rtl/alu_sequencer.sv | 92 +++++++++
 tb/tb_alu_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake and ALU-facing bus of the sequencer
interface alu_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 7
);
  logic [31:0] instrIn;
  logic instrValid;
  logic instrReady;
  logic [OP_WIDTH-1:0] controlUnitOut;
  logic [DATA_WIDTH-1:0] aluA;
  logic [DATA_WIDTH-1:0] aluB;
  logic [DATA_WIDTH-1:0] aluIn;
  logic carryIn;
  logic negativeIn;
  logic zeroIn;
  logic parityIn;
  logic overflowIn;
  logic [DATA_WIDTH-1:0] resultOut;
  logic [4:0] flagsOut;
  logic doneOut;
  logic errorOut;
  modport master (
    output instrIn, instrValid, aluIn, carryIn, negativeIn, zeroIn, parityIn, overflowIn,
    input instrReady, controlUnitOut, aluA, aluB, resultOut, flagsOut, doneOut, errorOut
  );
  modport slave (
    input instrIn, instrValid, aluIn, carryIn, negativeIn, zeroIn, parityIn, overflowIn,
    output instrReady, controlUnitOut, aluA, aluB, resultOut, flagsOut, doneOut, errorOut
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-phase control unit feeding a combinational ALU from an 8x32 register file
module alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 7
) (
  input logic clk,
  input logic reset,
  alu_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXECUTE = 2'd2;
  localparam logic [1:0] WRITEBACK = 2'd3;
  logic [1:0] r_state;
  logic [31:0] r_instr;
  logic [DATA_WIDTH-1:0] r_regs [8];
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_result_out;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [OP_WIDTH-1:0] r_op;
  logic [4:0] r_flags;
  logic [6:0] w_op;
  logic [2:0] w_rd;
  logic [2:0] w_rs1;
  logic [2:0] w_rs2;
  logic [15:0] w_imm;
  logic w_alu_op;
  logic w_loadi;
  logic w_legal;
  assign w_op = r_instr[31:25];
  assign w_rd = r_instr[24:22];
  assign w_rs1 = r_instr[21:19];
  assign w_rs2 = r_instr[18:16];
  assign w_imm = r_instr[15:0];
  assign w_alu_op = w_op <= 7'h06;
  assign w_loadi = w_op == 7'h40;
  assign w_legal = w_alu_op || w_loadi;
  assign bus.instrReady = r_state == IDLE;
  assign bus.doneOut = r_state == WRITEBACK;
  assign bus.errorOut = r_state == WRITEBACK && !w_legal;
  assign bus.controlUnitOut = r_op;
  assign bus.aluA = r_a;
  assign bus.aluB = r_b;
  assign bus.resultOut = r_result_out;
  assign bus.flagsOut = r_flags;
  // accept, decode, capture ALU result and write back, one phase per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_regs <= '{default: '0};
      r_result <= '0;
      r_result_out <= '0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.instrValid) begin
            r_instr <= bus.instrIn;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_a <= r_regs[w_rs1];
          r_b <= r_regs[w_rs2];
          r_op <= OP_WIDTH'(w_op);
          r_state <= EXECUTE;
        end
        EXECUTE: begin
          if (w_alu_op) begin
            r_result <= bus.aluIn;
            r_flags <= {bus.overflowIn, bus.parityIn, bus.zeroIn, bus.negativeIn, bus.carryIn};
          end else if (w_loadi) begin
            r_result <= DATA_WIDTH'(w_imm);
          end
          r_state <= WRITEBACK;
        end
        default: begin
          if (w_legal) begin
            r_regs[w_rd] <= r_result;
            r_result_out <= r_result;
          end
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench driving random and directed instructions through a model ALU
module tb_alu_sequencer;
  typedef struct {
    int unsigned cyc;
    logic err;
    logic [4:0] flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [6:0] op;
  } exp_t;
  logic clk;
  logic reset;
  int unsigned cyc;
  int unsigned last_c;
  int n_cmp;
  int n_bad;
  exp_t q[$];
  logic [31:0] m_r [8];
  logic [4:0] m_flags;
  logic [31:0] m_res;
  logic [36:0] alu_w;
  alu_sequencer_if bus ();
  alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  // combinational ALU: {overflow, parity, zero, negative, carry, result}
  function automatic logic [36:0] alu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic c;
    logic v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      7'h00: r = a | b;
      7'h01: r = a & b;
      7'h02: r = a ^ b;
      7'h03: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      7'h04: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      7'h05: begin
        r = a << 1;
        c = a[31];
      end
      7'h06: begin
        r = a >> 1;
        c = a[0];
      end
      default: r = '0;
    endcase
    return {v, ^r, r == 32'd0, r[31], c, r};
  endfunction
  assign alu_w = alu(bus.controlUnitOut, bus.aluA, bus.aluB);
  assign bus.aluIn = alu_w[31:0];
  assign {bus.overflowIn, bus.parityIn, bus.zeroIn, bus.negativeIn, bus.carryIn} = alu_w[36:32];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2, input logic [15:0] imm);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), imm};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_flags = '0;
    m_res = '0;
    q.delete();
  endtask
  task automatic predict(input logic [31:0] w, input int unsigned c);
    exp_t e;
    logic [36:0] t;
    logic [6:0] op;
    op = w[31:25];
    e.a = m_r[w[21:19]];
    e.b = m_r[w[18:16]];
    e.op = op;
    e.cyc = c + 3;
    e.err = 1'b0;
    if (op <= 7'h06) begin
      t = alu(op, e.a, e.b);
      m_flags = t[36:32];
      m_res = t[31:0];
      m_r[w[24:22]] = m_res;
    end else if (op == 7'h40) begin
      m_res = {16'b0, w[15:0]};
      m_r[w[24:22]] = m_res;
    end else begin
      e.err = 1'b1;
    end
    e.flags = m_flags;
    e.res = m_res;
    q.push_back(e);
  endtask
  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [31:0] w, input bit hold, input int exp_wait);
    int waited;
    waited = 0;
    bus.instrIn = w;
    bus.instrValid = 1'b1;
    while (!bus.instrReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end else begin
      if (exp_wait >= 0) begin
        chk("ready_low_cycles", 64'(waited), 64'(exp_wait));
        chk("accept_spacing", 64'(cyc - last_c), 64'd4);
      end
      last_c = cyc;
      predict(w, cyc);
      @(posedge clk);
    end
    @(negedge clk);
    if (!hold) bus.instrValid = 1'b0;
  endtask
  // monitor: pop the scoreboard on every completion pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.errorOut && !bus.doneOut) chk("error_without_done", 64'(bus.errorOut), 64'd0);
        if (bus.doneOut) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 64'(bus.doneOut), 64'd0);
          end else begin
            e = q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("errorOut", 64'(bus.errorOut), 64'(e.err));
            chk("flagsOut", 64'(bus.flagsOut), 64'(e.flags));
            chk("aluA", 64'(bus.aluA), 64'(e.a));
            chk("aluB", 64'(bus.aluB), 64'(e.b));
            chk("controlUnitOut", 64'(bus.controlUnitOut), 64'(e.op));
            @(negedge clk);
            chk("done_not_consecutive", 64'(bus.doneOut), 64'd0);
            chk("resultOut", 64'(bus.resultOut), 64'(e.res));
          end
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [6:0] op;
    int r;
    cyc = 0;
    last_c = 0;
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    reset = 1'b1;
    bus.instrValid = 1'b1;
    bus.instrIn = mk(7'h40, 1, 0, 0, 16'h1234);
    repeat (2) @(negedge clk);
    chk("rst_controlUnitOut", 64'(bus.controlUnitOut), 64'd0);
    chk("rst_aluA", 64'(bus.aluA), 64'd0);
    chk("rst_aluB", 64'(bus.aluB), 64'd0);
    chk("rst_resultOut", 64'(bus.resultOut), 64'd0);
    chk("rst_flagsOut", 64'(bus.flagsOut), 64'd0);
    chk("rst_doneOut", 64'(bus.doneOut), 64'd0);
    chk("rst_errorOut", 64'(bus.errorOut), 64'd0);
    reset = 1'b0;
    bus.instrValid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.instrReady), 64'd1);
    repeat (3) @(negedge clk);
    issue(mk(7'h40, 1, 0, 0, 16'd5), 0, -1);
    issue(mk(7'h40, 2, 0, 0, 16'd3), 0, -1);
    issue(mk(7'h03, 3, 1, 2, 16'd0), 0, -1);
    issue(mk(7'h02, 6, 1, 1, 16'd0), 0, -1);
    issue(mk(7'h40, 4, 0, 0, 16'd0), 0, -1);
    issue(mk(7'h0F, 1, 2, 3, 16'd0), 0, -1);
    issue(mk(7'h05, 5, 1, 0, 16'd0), 0, -1);
    repeat (4) @(negedge clk);
    chk("sum_r3", 64'(m_r[3]), 64'd8);
    chk("shl_r5", 64'(m_r[5]), 64'd10);
    issue(mk(7'h03, 7, 3, 5, 16'd0), 1, -1);
    issue(mk(7'h04, 0, 7, 1, 16'd0), 1, 3);
    issue(mk(7'h06, 2, 0, 0, 16'd0), 0, 3);
    repeat (4) @(negedge clk);
    issue(mk(7'h40, 7, 0, 0, 16'd0), 0, -1);
    repeat (4) @(negedge clk);
    issue(mk(7'h04, 7, 3, 1, 16'd0), 0, -1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_ready", 64'(bus.instrReady), 64'd1);
    chk("midrst_done", 64'(bus.doneOut), 64'd0);
    chk("midrst_resultOut", 64'(bus.resultOut), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(mk(7'h40, 1, 0, 0, 16'd9), 0, -1);
    issue(mk(7'h03, 6, 7, 1, 16'd0), 0, -1);
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      op = r <= 6 ? 7'(r) : r <= 8 ? 7'h40 : 7'($urandom_range(7, 63));
      issue(mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)), 0, -1);
    end
    repeat (8) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
